// File: rtl/regfile_dbg_pkg.sv
// -----------------------------------------------------------------------------
// regfile_dbg_pkg
// Shared definitions for the register-file debug/test-access port.
// The register-file geometry constants live here so that the register file
// instance and the debug controller are always sized from the same numbers.
// -----------------------------------------------------------------------------
package regfile_dbg_pkg;

  localparam int NUM_REGS = 4;
  localparam int DATA_W   = 8;
  localparam int ADDR_W   = $clog2(NUM_REGS);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DUMP,
    DONE
  } dbg_state_t;

  typedef enum logic {
    OP_LOAD = 1'b0,
    OP_DUMP = 1'b1
  } dbg_op_t;

endpackage

// File: rtl/regfile_dbg_port.sv
// -----------------------------------------------------------------------------
// regfile_dbg_port
// Debug/test-access controller for the register file. Accepts LOAD/DUMP
// commands over a valid/ready handshake. LOAD streams bytes into consecutive
// registers through the write port; DUMP reads consecutive registers through
// one combinational read port and streams them out through a one-entry output
// register. While busy the controller owns the write port and that read port.
//
// Ports:
//   Clk, Reset            clock, asynchronous active-high reset
//   cmd_valid/ready       command handshake; cmd_op 0=LOAD 1=DUMP,
//   cmd_addr, cmd_len     start register and beat count minus one
//   wr_valid/ready/data   LOAD byte stream in
//   rd_valid/ready/data   DUMP byte stream out, rd_last on the final beat
//   rf_we/waddr/wdata     register-file write port
//   rf_raddr/rf_rdata     register-file combinational read port
//   busy                  high outside IDLE, core must stall
//   done                  one-cycle pulse at command completion
// -----------------------------------------------------------------------------
module regfile_dbg_port #(
  parameter  int NUM_REGS = regfile_dbg_pkg::NUM_REGS,
  parameter  int DATA_W   = regfile_dbg_pkg::DATA_W,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [ADDR_W-1:0] rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              busy,
  output logic              done
);

  import regfile_dbg_pkg::*;

  dbg_state_t        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] remaining_q, remaining_d;
  logic [DATA_W-1:0] rdData_q, rdData_d;
  logic              rdValid_q, rdValid_d;
  logic              rdLast_q, rdLast_d;

  // Output slot can take a new byte when it is empty or being drained now.
  logic slotFree;
  // Once the last beat sits in the output register nothing is left to fetch.
  logic fetchPending;

  assign slotFree     = !rdValid_q || rd_ready;
  assign fetchPending = !(rdValid_q && rdLast_q);

  // All state, including the DUMP output register, clears asynchronously so
  // the core regains the register-file ports the instant Reset rises.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      remaining_q <= '0;
      rdData_q    <= '0;
      rdValid_q   <= 1'b0;
      rdLast_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      remaining_q <= remaining_d;
      rdData_q    <= rdData_d;
      rdValid_q   <= rdValid_d;
      rdLast_q    <= rdLast_d;
    end
  end

  // Next-state and output decode. The pointer wraps naturally because it is
  // exactly ADDR_W bits wide, giving mod-NUM_REGS address arithmetic. In LOAD
  // the write port is a straight combinational pass-through so a byte lands
  // on the same edge as its handshake.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    remaining_d = remaining_q;
    rdData_d    = rdData_q;
    rdValid_d   = rdValid_q;
    rdLast_d    = rdLast_q;
    cmd_ready   = 1'b0;
    wr_ready    = 1'b0;
    rf_we       = 1'b0;
    rf_wdata    = '0;
    busy        = 1'b1;
    done        = 1'b0;

    case (state_q)
      IDLE: begin
        busy      = 1'b0;
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          ptr_d       = cmd_addr;
          remaining_d = cmd_len;
          state_d     = (dbg_op_t'(cmd_op) == OP_DUMP) ? DUMP : LOAD;
        end
      end

      LOAD: begin
        wr_ready = 1'b1;
        rf_we    = wr_valid;
        rf_wdata = wr_data;
        if (wr_valid) begin
          ptr_d       = ptr_q + 1'b1;
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == '0) begin
            state_d = DONE;
          end
        end
      end

      DUMP: begin
        if (rdValid_q && rd_ready && rdLast_q) begin
          rdValid_d = 1'b0;
          rdLast_d  = 1'b0;
          state_d   = DONE;
        end else if (slotFree && fetchPending) begin
          rdData_d  = rf_rdata;
          rdValid_d = 1'b1;
          rdLast_d  = (remaining_q == '0);
          ptr_d     = ptr_q + 1'b1;
          if (remaining_q != '0) begin
            remaining_d = remaining_q - 1'b1;
          end
        end
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign rf_waddr = ptr_q;
  assign rf_raddr = ptr_q;
  assign rd_valid = rdValid_q;
  assign rd_data  = rdData_q;
  assign rd_last  = rdLast_q;

endmodule

// File: tb/tb_regfile_dbg_port.sv
// -----------------------------------------------------------------------------
// tb_regfile_dbg_port
// Self-checking bench for regfile_dbg_port. A small register-file array is
// attached to the DUT's ports; a shadow copy of the register contents is kept
// and updated from command semantics alone to predict every write and every
// dumped byte.
// -----------------------------------------------------------------------------
module tb_regfile_dbg_port;

  import regfile_dbg_pkg::*;

  logic              Clk = 1'b0;
  logic              Reset;
  logic              cmd_valid, cmd_ready, cmd_op;
  logic [ADDR_W-1:0] cmd_addr, cmd_len;
  logic              wr_valid, wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid, rd_ready, rd_last;
  logic [DATA_W-1:0] rd_data;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr, rf_raddr;
  logic [DATA_W-1:0] rf_wdata, rf_rdata;
  logic              busy, done;

  int nChecks = 0;
  int nFails  = 0;

  regfile_dbg_port dut (
    .Clk(Clk), .Reset(Reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .busy(busy), .done(done)
  );

  always #5 Clk = ~Clk;

  // Register file attached to the DUT: synchronous write, combinational read.
  logic [DATA_W-1:0] rfMem [NUM_REGS];
  assign rf_rdata = rfMem[rf_raddr];
  always @(posedge Clk) begin
    if (rf_we) rfMem[rf_waddr] <= rf_wdata;
  end

  // Passive monitor: logs every write and every accepted DUMP beat, counts
  // done pulses, and flags any write that is not a LOAD byte handshake.
  logic [ADDR_W-1:0] wAddrQ[$];
  logic [DATA_W-1:0] wDataQ[$];
  logic [DATA_W-1:0] rDataQ[$];
  logic              rLastQ[$];
  int doneCount = 0;
  int weBadCount = 0;
  always @(negedge Clk) begin
    if (!Reset) begin
      if (rf_we) begin
        wAddrQ.push_back(rf_waddr);
        wDataQ.push_back(rf_wdata);
      end
      if (rd_valid && rd_ready) begin
        rDataQ.push_back(rd_data);
        rLastQ.push_back(rd_last);
      end
      if (done) doneCount++;
      if (rf_we !== (wr_valid && wr_ready)) weBadCount++;
    end
  end

  // Shadow register contents, maintained from command semantics.
  logic [DATA_W-1:0] model [NUM_REGS];

  typedef struct {
    bit          op;
    logic [1:0]  addr;
    logic [1:0]  len;
    logic [31:0] din;
    logic [7:0]  expA;
    logic [31:0] expD;
  } vec_t;

  vec_t vecs [6];

  function automatic vec_t mkVec(bit op, logic [1:0] addr, logic [1:0] len,
                                 logic [31:0] din, logic [7:0] expA, logic [31:0] expD);
    vec_t v;
    v.op = op; v.addr = addr; v.len = len; v.din = din; v.expA = expA; v.expD = expD;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Issue one command and run it to completion with optional wr_valid gaps
  // and rd_ready stalls; bounded so a hung DUT still reaches the summary.
  task automatic applyStimulus(input bit op, input logic [1:0] addr, input logic [1:0] len,
                               input logic [31:0] din, input int gapPct, input int stallPct);
    int  beat = 0;
    int  cyc  = 0;
    bit  fin  = 0;
    bit  accepted;
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_len = len;
    @(negedge Clk);
    accepted = cmd_ready;
    tick();
    cmd_valid = 1'b0;
    checkOutput("cmd accepted", accepted, 1);
    while (!fin && cyc < 300) begin
      if (op == OP_LOAD) begin
        wr_valid = (beat <= int'(len)) && ($urandom_range(99) >= gapPct);
        wr_data  = din[8*(beat % 4) +: 8];
      end else begin
        wr_valid = $urandom_range(1);
        wr_data  = 8'($urandom);
      end
      rd_ready = ($urandom_range(99) >= stallPct);
      @(negedge Clk);
      if (wr_valid && wr_ready) beat++;
      if (done) fin = 1;
      tick();
      cyc++;
    end
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    if (!fin) checkOutput("cmd timeout", 0, 1);
  endtask

  // Compare what the monitor logged since the given snapshot against the
  // expected addresses/bytes of one command.
  task automatic checkCmd(input string tag, input bit op, input logic [1:0] len,
                          input logic [7:0] expA, input logic [31:0] expD,
                          input int w0, input int r0, input int d0);
    int n = int'(len) + 1;
    checkOutput({tag, " doneCount"}, doneCount - d0, 1);
    if (op == OP_LOAD) begin
      checkOutput({tag, " writes"}, wAddrQ.size() - w0, n);
      checkOutput({tag, " beats"}, rDataQ.size() - r0, 0);
      for (int i = 0; i < n && w0 + i < wAddrQ.size(); i++) begin
        checkOutput($sformatf("%s waddr%0d", tag, i), 32'(wAddrQ[w0+i]), 32'(expA[2*i +: 2]));
        checkOutput($sformatf("%s wdata%0d", tag, i), 32'(wDataQ[w0+i]), 32'(expD[8*i +: 8]));
      end
    end else begin
      checkOutput({tag, " writes"}, wAddrQ.size() - w0, 0);
      checkOutput({tag, " beats"}, rDataQ.size() - r0, n);
      for (int i = 0; i < n && r0 + i < rDataQ.size(); i++) begin
        checkOutput($sformatf("%s rdata%0d", tag, i), 32'(rDataQ[r0+i]), 32'(expD[8*i +: 8]));
        checkOutput($sformatf("%s rlast%0d", tag, i), 32'(rLastQ[r0+i]), (i == n - 1) ? 1 : 0);
      end
    end
  endtask

  task automatic compareRegs(input string tag);
    for (int i = 0; i < NUM_REGS; i++) begin
      checkOutput($sformatf("%s reg%0d", tag, i), 32'(rfMem[i]), 32'(model[i]));
    end
  endtask

  task automatic modelLoad(input logic [1:0] addr, input logic [1:0] len, input logic [31:0] din);
    for (int i = 0; i <= int'(len); i++) begin
      model[(int'(addr) + i) % NUM_REGS] = din[8*i +: 8];
    end
  endtask

  // Main sequence: reset, table vectors, hand-written corner cases, random.
  initial begin
    int w0, r0, d0;
    Reset = 1'b1;
    cmd_valid = 0; cmd_op = 0; cmd_addr = 0; cmd_len = 0;
    wr_valid = 0; wr_data = 0; rd_ready = 0;
    for (int i = 0; i < NUM_REGS; i++) model[i] = '0;

    vecs[0] = mkVec(0, 2'd0, 2'd3, 32'h44332211, 8'b11_10_01_00, 32'h44332211);
    vecs[1] = mkVec(0, 2'd0, 2'd3, 32'hD3C2B1A0, 8'b11_10_01_00, 32'hD3C2B1A0);
    vecs[2] = mkVec(1, 2'd2, 2'd3, 32'h0,        8'h0,           32'hB1A0D3C2);
    vecs[3] = mkVec(1, 2'd1, 2'd1, 32'h0,        8'h0,           32'h0000C2B1);
    vecs[4] = mkVec(0, 2'd3, 2'd1, 32'h00006B5A, 8'b00_00_00_11, 32'h00006B5A);
    vecs[5] = mkVec(1, 2'd3, 2'd3, 32'h0,        8'h0,           32'hC2B16B5A);

    repeat (2) @(posedge Clk);
    #1;
    checkOutput("rst cmd_ready", cmd_ready, 1);
    checkOutput("rst wr_ready", wr_ready, 0);
    checkOutput("rst rf_we", rf_we, 0);
    checkOutput("rst busy", busy, 0);
    checkOutput("rst done", done, 0);
    checkOutput("rst rd_valid", rd_valid, 0);
    checkOutput("rst rd_data", rd_data, 0);
    checkOutput("rst rd_last", rd_last, 0);
    checkOutput("rst rf_waddr", rf_waddr, 0);
    checkOutput("rst rf_wdata", rf_wdata, 0);
    checkOutput("rst rf_raddr", rf_raddr, 0);
    Reset = 1'b0;
    tick();

    for (int v = 0; v < 6; v++) begin
      w0 = wAddrQ.size(); r0 = rDataQ.size(); d0 = doneCount;
      applyStimulus(vecs[v].op, vecs[v].addr, vecs[v].len, vecs[v].din, 25, 25);
      checkCmd($sformatf("vec%0d", v), vecs[v].op, vecs[v].len, vecs[v].expA, vecs[v].expD, w0, r0, d0);
      if (vecs[v].op == OP_LOAD) modelLoad(vecs[v].addr, vecs[v].len, vecs[v].din);
    end
    compareRegs("table");

    // Back-to-back LOAD: four consecutive writes, done the next cycle.
    cmd_valid = 1; cmd_op = 0; cmd_addr = 0; cmd_len = 3;
    @(negedge Clk); checkOutput("h1 cmd_ready", cmd_ready, 1);
    tick(); cmd_valid = 0;
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1; wr_data = 8'(8'h11 * (i + 1));
      @(negedge Clk);
      checkOutput($sformatf("h1 we%0d", i), rf_we, 1);
      checkOutput($sformatf("h1 waddr%0d", i), rf_waddr, i);
      checkOutput($sformatf("h1 wdata%0d", i), rf_wdata, 8'h11 * (i + 1));
      tick();
    end
    wr_valid = 0;
    @(negedge Clk); checkOutput("h1 done", done, 1); checkOutput("h1 noWe", rf_we, 0);
    tick();
    @(negedge Clk); checkOutput("h1 idle busy", busy, 0); checkOutput("h1 idle done", done, 0);
    tick();
    modelLoad(2'd0, 2'd3, 32'h44332211);
    compareRegs("h1");

    // DUMP with wrap, rd_ready high: first beat two cycles after acceptance.
    rd_ready = 1;
    cmd_valid = 1; cmd_op = 1; cmd_addr = 2; cmd_len = 3;
    @(negedge Clk); checkOutput("h2 cmd_ready", cmd_ready, 1);
    tick(); cmd_valid = 0;
    @(negedge Clk); checkOutput("h2 early valid", rd_valid, 0); checkOutput("h2 busy", busy, 1);
    tick();
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      checkOutput($sformatf("h2 valid%0d", i), rd_valid, 1);
      checkOutput($sformatf("h2 data%0d", i), rd_data, model[(2 + i) % NUM_REGS]);
      checkOutput($sformatf("h2 last%0d", i), rd_last, (i == 3) ? 1 : 0);
      tick();
    end
    @(negedge Clk); checkOutput("h2 done", done, 1); checkOutput("h2 valid off", rd_valid, 0);
    tick();

    // DUMP with rd_ready low for three cycles: output must hold.
    rd_ready = 0;
    r0 = rDataQ.size();
    cmd_valid = 1; cmd_op = 1; cmd_addr = 1; cmd_len = 1;
    tick(); cmd_valid = 0;
    tick();
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      checkOutput($sformatf("h3 hold valid%0d", k), rd_valid, 1);
      checkOutput($sformatf("h3 hold data%0d", k), rd_data, model[1]);
      checkOutput($sformatf("h3 hold last%0d", k), rd_last, 0);
      tick();
    end
    rd_ready = 1;
    @(negedge Clk); checkOutput("h3 beat0", rd_data, model[1]);
    tick();
    @(negedge Clk); checkOutput("h3 beat1", rd_data, model[2]); checkOutput("h3 last", rd_last, 1);
    tick();
    @(negedge Clk); checkOutput("h3 done", done, 1);
    tick();
    rd_ready = 0;
    checkOutput("h3 beat count", rDataQ.size() - r0, 2);

    // LOAD with a wr_valid gap and a command offered while busy.
    w0 = wAddrQ.size();
    cmd_valid = 1; cmd_op = 0; cmd_addr = 3; cmd_len = 1;
    tick();
    cmd_op = 1; wr_valid = 1; wr_data = 8'hE3;
    @(negedge Clk);
    checkOutput("h4 busy cmd_ready", cmd_ready, 0);
    checkOutput("h4 we0", rf_we, 1); checkOutput("h4 waddr0", rf_waddr, 3);
    tick();
    wr_valid = 0;
    for (int k = 0; k < 2; k++) begin
      @(negedge Clk);
      checkOutput($sformatf("h4 gap we%0d", k), rf_we, 0);
      checkOutput($sformatf("h4 gap cmd_ready%0d", k), cmd_ready, 0);
      tick();
    end
    wr_valid = 1; wr_data = 8'hE0;
    @(negedge Clk); checkOutput("h4 we1", rf_we, 1); checkOutput("h4 waddr1", rf_waddr, 0);
    tick();
    wr_valid = 0; cmd_valid = 0;
    @(negedge Clk); checkOutput("h4 done", done, 1);
    tick();
    @(negedge Clk); checkOutput("h4 idle", busy, 0);
    checkOutput("h4 write count", wAddrQ.size() - w0, 2);
    model[3] = 8'hE3; model[0] = 8'hE0;
    compareRegs("h4");

    // Reset mid-DUMP after one of four beats.
    rd_ready = 1;
    cmd_valid = 1; cmd_op = 1; cmd_addr = 0; cmd_len = 3;
    tick(); cmd_valid = 0;
    tick();
    @(negedge Clk); checkOutput("h5 first beat", rd_valid, 1);
    tick();
    Reset = 1;
    #1;
    checkOutput("h5 rst rd_valid", rd_valid, 0);
    checkOutput("h5 rst busy", busy, 0);
    checkOutput("h5 rst done", done, 0);
    checkOutput("h5 rst cmd_ready", cmd_ready, 1);
    tick();
    Reset = 0; rd_ready = 0;
    @(negedge Clk); checkOutput("h5 post cmd_ready", cmd_ready, 1); checkOutput("h5 post busy", busy, 0);
    tick();
    compareRegs("h5");

    // Reset mid-LOAD after two of four beats.
    w0 = wAddrQ.size();
    cmd_valid = 1; cmd_op = 0; cmd_addr = 0; cmd_len = 3;
    tick(); cmd_valid = 0;
    for (int i = 0; i < 2; i++) begin
      wr_valid = 1; wr_data = 8'(8'h91 + i);
      tick();
    end
    wr_data = 8'h93;
    Reset = 1;
    #1;
    checkOutput("h6 rst rf_we", rf_we, 0);
    checkOutput("h6 rst wr_ready", wr_ready, 0);
    checkOutput("h6 rst busy", busy, 0);
    tick();
    Reset = 0;
    @(negedge Clk); checkOutput("h6 idle rf_we", rf_we, 0);
    tick();
    wr_valid = 0;
    checkOutput("h6 write count", wAddrQ.size() - w0, 2);
    model[0] = 8'h91; model[1] = 8'h92;
    compareRegs("h6");

    // Randomized commands checked against the shadow register model.
    for (int t = 0; t < 40; t++) begin
      bit          op;
      logic [1:0]  addr, len;
      logic [31:0] din, expD;
      logic [7:0]  expA;
      int          a;
      op = $urandom_range(1); addr = 2'($urandom); len = 2'($urandom); din = $urandom;
      expA = '0; expD = '0;
      for (int i = 0; i <= int'(len); i++) begin
        a = (int'(addr) + i) % NUM_REGS;
        expA[2*i +: 2] = 2'(a);
        expD[8*i +: 8] = op ? model[a] : din[8*i +: 8];
      end
      w0 = wAddrQ.size(); r0 = rDataQ.size(); d0 = doneCount;
      applyStimulus(op, addr, len, din, 30, 30);
      checkCmd($sformatf("rnd%0d", t), op, len, expA, expD, w0, r0, d0);
      if (op == OP_LOAD) modelLoad(addr, len, din);
      compareRegs($sformatf("rnd%0d", t));
    end

    checkOutput("stray writes", weBadCount, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
